keypad_scanner: RTL and testbench
=================================

# keypad_scanner

- Input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 active-low matrix keypad one column at a time, rebuilds a full key snapshot every scan and debounces it over several scans.
- For each debounced press, emits a one-cycle hex key event and shifts the digit into a 16-bit entry register.
- Sits between the board keypad header and the display/counter logic, which consumes `value` as four hex digits.

## Interface
- `CLK_HZ`, default 50000000: input clock frequency.
- `SCAN_HZ`, default 1000: column-step rate. Tick period is CLK_HZ/SCAN_HZ cycles, integer, ≥ 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release, ≥ 1.
- `CLOCK_50`  in  1: sole clock, all logic on rising edge.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `rows`  in  4: keypad row lines, pulled up; 0 = contact closed on the driven column.
- `cols`  out  4: column drives, active-low; exactly one bit 0 at all times.
- `key_code`  out  4: code of the last accepted key.
- `key_valid`  out  1: one-cycle pulse marking a new `key_code`.
- `value`  out  16: last four accepted digits; newest in [3:0].

## Operation
- Reset values: `cols`=4'b1110, `key_code`=0, `key_valid`=0, `value`=0. FSM in IDLE; tick counter, column index, snapshot and debounce counter all 0.
- `rows` pass through a 2-flop synchronizer before any use.
- Tick generator: counter 0..CLK_HZ/SCAN_HZ-1, one-cycle `tick` at terminal count, then wraps to 0.
- On `tick`:
  - Store inverted synced rows of column `col_idx` into snapshot bits [4*r+col_idx], for r = 0..3.
  - Then `col_idx` <= `col_idx`+1, wrapping 3→0. `cols` = ~(1<<col_idx).
- A scan ends on the tick that samples column 3. The scan result is classified as:
  - **KEY(c)**: exactly one snapshot bit set; c = 4*row+col.
  - **NONE**: zero bits set.
  - **MULTI**: two or more bits set. Treated as NONE for acceptance and as not-NONE for release.
- Debounce FSM, evaluated only at scan end; `cand` is 4 bits, `cnt` is sized for DEBOUNCE_SCANS:
  - **IDLE**: KEY(c) → `cand`=c, `cnt`=1. Go to HELD with accept if DEBOUNCE_SCANS==1, otherwise to CONFIRM. NONE/MULTI → stay.
  - **CONFIRM**: KEY(`cand`) → `cnt`++; on reaching DEBOUNCE_SCANS, accept and go to HELD. Anything else → IDLE, `cnt`=0.
  - **HELD**: NONE → `cnt`++ (reset to 0 on entry to HELD); on reaching DEBOUNCE_SCANS go to IDLE. KEY/MULTI → `cnt`=0, stay. No autorepeat.
- Accept action, same cycle:
  - `key_code`<=`cand`, `key_valid`<=1.
  - `value`<={`value`[11:0],`cand`}; the oldest digit drops off.
- `key_valid` is 0 in every other cycle.
- Asserting `RESET_N` low mid-scan or mid-debounce immediately restores all reset values. No event is emitted for a press that was in progress.

## Timing
- Each column is driven for one full tick period before its rows are sampled; this is the settle time.
- `key_valid` rises in the cycle after the scan-end tick that completes acceptance. It lasts exactly one cycle. `key_code` and `value` update in that same cycle.
- Press latency: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scan periods (4 ticks each) from a stable closure, plus 2 synchronizer cycles.
- Minimum spacing between accepted events: 2*DEBOUNCE_SCANS scans.

## Structure
- Shared package:
  - FSM state enum (IDLE, CONFIRM, HELD).
  - Scan-class enum (NONE, KEY, MULTI).
  - NCOLS=4, NROWS=4.
- One sub-module, `scan_tick`: the divider producing `tick` from CLK_HZ/SCAN_HZ. Same role as the existing slow-clock divider, but it outputs an enable pulse, not a clock.
- The snapshot, classifier and FSM live in the top.

## Test plan
Bench parameters: CLK_HZ=16, SCAN_HZ=4 (tick every 4 cycles), DEBOUNCE_SCANS=2. Keypad model shorts row r to column c when key (r,c) is held.
- Reset release with no keys → `cols` steps 1110, 1101, 1011, 0111 every 4 cycles; `key_valid` never rises; `value`=0.
- Hold key (row 1, col 2) for 4 scans → exactly one `key_valid` pulse, `key_code`=6, `value`=16'h0006; holding longer gives no repeat.
- Release, then press keys 1, 2, 3, 4, 5 in turn (each pressed 3 scans, released 3 scans) → five pulses; final `value`=16'h2345.
- Hold key 0 for a single scan only → no pulse; FSM returns to IDLE.
- Press keys 4 and 5 together for 5 scans → no pulse; while HELD after key 9, an added second key keeps the FSM in HELD.
- Assert `RESET_N` low during CONFIRM with key 7 held → outputs return to reset values at once; after release of reset with 7 still held, a fresh debounce yields one pulse, `value`=16'h0007.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types and constants for the keypad scanner
package keypad_scanner_pkg;

    localparam int NCOLS = 4;
    localparam int NROWS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE  = 2'd0,
        SCAN_KEY   = 2'd1,
        SCAN_MULTI = 2'd2
    } scan_class_t;

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// rtl/keypad_scanner_scan_tick.sv - divider producing a one-cycle column-step enable
module scan_tick #(
    parameter int CLK_HZ  = 50000000,
    parameter int SCAN_HZ = 1000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    output logic tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int TW  = $clog2(DIV);

    logic [TW-1:0] count;

    assign tick = (count == TW'(DIV - 1));

    // Free-running counter that wraps to zero right after its terminal count
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + TW'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and hex entry register
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] value
);

    localparam int            CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE_SCANS);

    logic          tick;
    logic [3:0]    rows_meta;
    logic [3:0]    rows_sync;
    logic [1:0]    col_idx;
    logic [15:0]   snapshot;
    logic [15:0]   snap_next;
    logic [4:0]    ones;
    logic [3:0]    scan_code;
    scan_class_t   scan_class;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic          scan_end;

    scan_tick #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_scan_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .tick     (tick)
    );

    // Drive exactly one column low, selected by the current column index
    assign cols     = ~(4'b0001 << col_idx);
    assign scan_end = tick && (col_idx == 2'd3);

    // Two-flop synchronizer; idle keypad lines are pulled high
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    // Snapshot as it will look after this tick, so scan end classifies column 3 too
    always_comb begin
        snap_next = snapshot;
        for (int r = 0; r < NROWS; r++)
            snap_next[{2'(r), col_idx}] = ~rows_sync[r];
    end

    // Classify the completed scan by number of closed contacts
    always_comb begin
        ones      = '0;
        scan_code = '0;
        for (int i = 0; i < NROWS * NCOLS; i++) begin
            if (snap_next[i]) begin
                ones      = ones + 5'd1;
                scan_code = 4'(i);
            end
        end
        if (ones == 5'd0)
            scan_class = SCAN_NONE;
        else if (ones == 5'd1)
            scan_class = SCAN_KEY;
        else
            scan_class = SCAN_MULTI;
    end

    // Column stepping and snapshot capture on every tick
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            col_idx  <= '0;
            snapshot <= '0;
        end else if (tick) begin
            snapshot <= snap_next;
            col_idx  <= col_idx + 2'd1;
        end
    end

    // Debounce FSM evaluated once per full scan, with registered key outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            value     <= '0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (scan_class == SCAN_KEY) begin
                            cand <= scan_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= HELD;
                                cnt       <= '0;
                                key_code  <= scan_code;
                                key_valid <= 1'b1;
                                value     <= {value[11:0], scan_code};
                            end else begin
                                state <= CONFIRM;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    CONFIRM: begin
                        if (scan_class == SCAN_KEY && scan_code == cand) begin
                            if (cnt + CW'(1) == DB) begin
                                state     <= HELD;
                                cnt       <= '0;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                value     <= {value[11:0], cand};
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (scan_class == SCAN_NONE) begin
                            if (cnt + CW'(1) == DB) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int SCAN_CYC = 16;

    logic        CLOCK_50;
    logic        RESET_N;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] value;

    logic [15:0] held;
    int          checks;
    int          errors;
    int          pulses;
    int          doubles;
    logic [3:0]  last_code;
    logic        prev_valid;

    keypad_scanner #(
        .CLK_HZ         (16),
        .SCAN_HZ        (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .value     (value)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Keypad model: row r pulled low when a held key in row r sits on the driven column
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[4*r+c] && !cols[c])
                    rows[r] = 1'b0;
    end

    // Pulse monitor sampled on the falling edge
    initial begin
        pulses     = 0;
        doubles    = 0;
        last_code  = '0;
        prev_valid = 1'b0;
    end
    always @(negedge CLOCK_50) begin
        if (key_valid) begin
            pulses    = pulses + 1;
            last_code = key_code;
            if (prev_valid)
                doubles = doubles + 1;
        end
        prev_valid = key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scans(input int n);
        repeat (n * SCAN_CYC) @(negedge CLOCK_50);
    endtask

    task automatic press_release(input int code);
        held = 16'(1) << code;
        scans(3);
        held = '0;
        scans(3);
    endtask

    initial begin
        int waited;
        checks  = 0;
        errors  = 0;
        held    = '0;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Reset state
        chk("reset_cols", 32'(cols), 32'hE);
        chk("reset_key_code", 32'(key_code), 32'h0);
        chk("reset_key_valid", 32'(key_valid), 32'h0);
        chk("reset_value", 32'(value), 32'h0);

        // Column stepping with no keys
        RESET_N = 1'b1;
        chk("cols_step0", 32'(cols), 32'hE);
        repeat (4) @(negedge CLOCK_50);
        chk("cols_step1", 32'(cols), 32'hD);
        repeat (4) @(negedge CLOCK_50);
        chk("cols_step2", 32'(cols), 32'hB);
        repeat (4) @(negedge CLOCK_50);
        chk("cols_step3", 32'(cols), 32'h7);
        repeat (4) @(negedge CLOCK_50);
        chk("cols_wrap", 32'(cols), 32'hE);
        scans(2);
        chk("idle_no_pulse", 32'(pulses), 32'd0);
        chk("idle_value", 32'(value), 32'h0);

        // Key (row 1, col 2) held 4 scans, then longer with no repeat
        held = 16'(1) << 6;
        scans(4);
        chk("k6_pulses", 32'(pulses), 32'd1);
        chk("k6_code", 32'(key_code), 32'h6);
        chk("k6_value", 32'(value), 32'h0006);
        scans(3);
        chk("k6_no_repeat", 32'(pulses), 32'd1);
        held = '0;
        scans(4);
        chk("k6_released", 32'(dut.state), 32'(IDLE));

        // Digit sequence 1..5
        for (int k = 1; k <= 5; k++)
            press_release(k);
        chk("seq_pulses", 32'(pulses), 32'd6);
        chk("seq_value", 32'(value), 32'h2345);
        chk("seq_last_code", 32'(last_code), 32'h5);

        // Single-scan press of key 0 is rejected
        held = 16'(1);
        scans(1);
        held = '0;
        scans(3);
        chk("short_no_pulse", 32'(pulses), 32'd6);
        chk("short_state", 32'(dut.state), 32'(IDLE));

        // Two keys together are never accepted
        held = (16'(1) << 4) | (16'(1) << 5);
        scans(5);
        chk("multi_no_pulse", 32'(pulses), 32'd6);
        chk("multi_state", 32'(dut.state), 32'(IDLE));
        held = '0;
        scans(3);

        // Key 9 accepted, then an extra key keeps the FSM held
        held = 16'(1) << 9;
        scans(4);
        chk("k9_pulses", 32'(pulses), 32'd7);
        chk("k9_value", 32'(value), 32'h3459);
        held = (16'(1) << 9) | 16'(1);
        scans(3);
        chk("k9_multi_held", 32'(dut.state), 32'(HELD));
        chk("k9_multi_no_pulse", 32'(pulses), 32'd7);
        held = 16'(1) << 9;
        scans(3);
        chk("k9_still_held", 32'(dut.state), 32'(HELD));
        held = '0;
        scans(4);
        chk("k9_released", 32'(dut.state), 32'(IDLE));

        // Reset during CONFIRM with key 7 held
        held   = 16'(1) << 7;
        waited = 0;
        while (dut.state != CONFIRM && waited < 200) begin
            @(negedge CLOCK_50);
            waited = waited + 1;
        end
        chk("confirm_reached", 32'(dut.state), 32'(CONFIRM));
        RESET_N = 1'b0;
        #1;
        chk("midrst_cols", 32'(cols), 32'hE);
        chk("midrst_key_code", 32'(key_code), 32'h0);
        chk("midrst_key_valid", 32'(key_valid), 32'h0);
        chk("midrst_value", 32'(value), 32'h0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        scans(4);
        chk("k7_pulses", 32'(pulses), 32'd8);
        chk("k7_code", 32'(key_code), 32'h7);
        chk("k7_value", 32'(value), 32'h0007);
        held = '0;
        scans(1);
        chk("single_cycle_pulses", 32'(doubles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
